fetch_if_id_stage: RTL and testbench

Instruction-fetch stage and IF/ID pipeline register. It drives the instruction-memory request handshake and owns the PC. It registers each fetched instruction with its PC into IF/ID, where the immediate generator and decoder consume it in ID. It honours hazard-unit stalls and branch/jump redirects (flush).

---
 rtl/rv_pipe_pkg.sv | 20 ++
 rtl/fetch_if_id_stage_if.sv | 24 ++
 rtl/if_id_reg.sv | 57 +++++
 rtl/fetch_if_id_stage.sv | 160 ++++++++++++++++
 tb/tb_fetch_if_id_stage.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/rv_pipe_pkg.sv
// Shared pipeline definitions: fetch FSM encoding, the canonical NOP word and PC helpers.
package rv_pipe_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR_WORD = 32'h0000_0013;
    localparam logic [XLEN-1:0] PC_INC = 32'd4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_WAIT_ID = 2'd2,
        ST_DROP    = 2'd3
    } fetch_state_e;

    // Instructions are word aligned, so the two low address bits carry no information.
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return pc & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_if_id_stage_if.sv
// Instruction-memory request/response bus between the fetch stage and instruction memory.
interface fetch_if_id_stage_if;
    import rv_pipe_pkg::*;

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_rvalid;
    logic [XLEN-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rvalid,
        output imem_rdata
    );

endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: load a new instruction, hold on stall, flush to a NOP bubble.
module if_id_reg
    import rv_pipe_pkg::*;
#(
    parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_WORD
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load_i,
    input  logic            flush_i,
    input  logic [XLEN-1:0] instr_i,
    input  logic [XLEN-1:0] pc_i,
    output logic            valid_o,
    output logic [XLEN-1:0] instr_o,
    output logic [XLEN-1:0] pc_o
);

    logic            valid_d, valid_q;
    logic [XLEN-1:0] instr_d, instr_q;
    logic [XLEN-1:0] pc_d, pc_q;

    // Next-state select: flush wins over load, otherwise hold.
    always_comb begin
        valid_d = valid_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        if (flush_i) begin
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
            pc_d    = 32'h0000_0000;
        end else if (load_i) begin
            valid_d = 1'b1;
            instr_d = instr_i;
            pc_d    = pc_i;
        end else begin
            valid_d = valid_q;
        end
    end

    // Register stage with asynchronous reset to an empty slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            instr_q <= NOP_INSTR;
            pc_q    <= 32'h0000_0000;
        end else begin
            valid_q <= valid_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
        end
    end

    assign valid_o = valid_q;
    assign instr_o = instr_q;
    assign pc_o    = pc_q;

endmodule

// File: rtl/fetch_if_id_stage.sv
// Instruction-fetch stage: owns the PC, runs the imem handshake, and feeds IF/ID with a one-entry skid.
module fetch_if_id_stage
    import rv_pipe_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
    parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_WORD
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        stall_i,
    input  logic                        redirect_valid,
    input  logic [XLEN-1:0]             redirect_pc,
    fetch_if_id_stage_if.master         imem,
    output logic                        if_id_valid,
    output logic [XLEN-1:0]             if_id_instr,
    output logic [XLEN-1:0]             if_id_pc
);

    fetch_state_e    state_d, state_q;
    logic [XLEN-1:0] pc_d, pc_q;
    logic [XLEN-1:0] addr_d, addr_q;
    logic            req_d, req_q;
    logic            skid_valid_d, skid_valid_q;
    logic [XLEN-1:0] skid_instr_d, skid_instr_q;
    logic [XLEN-1:0] skid_pc_d, skid_pc_q;

    logic            accept_s;
    logic            load_s;
    logic            flush_s;
    logic [XLEN-1:0] load_instr_s;
    logic [XLEN-1:0] load_pc_s;
    logic [XLEN-1:0] target_s;

    assign accept_s = !stall_i || !if_id_valid;
    assign target_s = align_pc(redirect_pc);

    // Fetch FSM next-state, PC, request and skid control; redirect overrides everything.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        addr_d       = addr_q;
        req_d        = req_q;
        skid_valid_d = skid_valid_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        load_s       = 1'b0;
        flush_s      = 1'b0;
        load_instr_s = imem.imem_rdata;
        load_pc_s    = pc_q;

        if (redirect_valid) begin
            pc_d         = target_s;
            flush_s      = 1'b1;
            skid_valid_d = 1'b0;
            // An outstanding request must still complete on its old address before refetching.
            if ((state_q == ST_REQ || state_q == ST_DROP) && !imem.imem_rvalid) begin
                state_d = ST_DROP;
                req_d   = 1'b1;
                addr_d  = addr_q;
            end else begin
                state_d = ST_REQ;
                req_d   = 1'b1;
                addr_d  = target_s;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_REQ;
                    req_d   = 1'b1;
                    addr_d  = pc_q;
                end
                ST_REQ: begin
                    if (imem.imem_rvalid && accept_s) begin
                        load_s  = 1'b1;
                        pc_d    = pc_q + PC_INC;
                        addr_d  = pc_q + PC_INC;
                        req_d   = 1'b1;
                        state_d = ST_REQ;
                    end else if (imem.imem_rvalid) begin
                        skid_valid_d = 1'b1;
                        skid_instr_d = imem.imem_rdata;
                        skid_pc_d    = pc_q;
                        pc_d         = pc_q + PC_INC;
                        addr_d       = pc_q + PC_INC;
                        req_d        = 1'b0;
                        state_d      = ST_WAIT_ID;
                    end else begin
                        state_d = ST_REQ;
                    end
                end
                ST_WAIT_ID: begin
                    if (!stall_i) begin
                        load_s       = 1'b1;
                        load_instr_s = skid_instr_q;
                        load_pc_s    = skid_pc_q;
                        skid_valid_d = 1'b0;
                        req_d        = 1'b1;
                        addr_d       = pc_q;
                        state_d      = ST_REQ;
                    end else begin
                        state_d = ST_WAIT_ID;
                    end
                end
                ST_DROP: begin
                    if (imem.imem_rvalid) begin
                        req_d   = 1'b1;
                        addr_d  = pc_q;
                        state_d = ST_REQ;
                    end else begin
                        state_d = ST_DROP;
                    end
                end
                default: begin
                    state_d      = ST_IDLE;
                    req_d        = 1'b0;
                    skid_valid_d = 1'b0;
                end
            endcase
        end
    end

    // FSM, PC, registered request outputs and skid storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            pc_q         <= RESET_PC;
            addr_q       <= RESET_PC;
            req_q        <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_instr_q <= NOP_INSTR;
            skid_pc_q    <= 32'h0000_0000;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            addr_q       <= addr_d;
            req_q        <= req_d;
            skid_valid_q <= skid_valid_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
        end
    end

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = addr_q;

    if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id_reg (
        .clk     (clk),
        .rst     (rst),
        .load_i  (load_s),
        .flush_i (flush_s),
        .instr_i (load_instr_s),
        .pc_i    (load_pc_s),
        .valid_o (if_id_valid),
        .instr_o (if_id_instr),
        .pc_o    (if_id_pc)
    );

endmodule

// File: tb/tb_fetch_if_id_stage.sv
// Directed bench for the fetch stage: bench-driven instruction memory, checks sampled on the falling edge.
module tb_fetch_if_id_stage;

    logic        clk;
    logic        rst;
    logic        stall_i;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_id_valid;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc;

    int total;
    int bad;

    localparam logic [31:0] NOP = 32'h0000_0013;

    fetch_if_id_stage_if bus ();

    fetch_if_id_stage #(
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (32'h0000_0013)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .stall_i        (stall_i),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem           (bus.master),
        .if_id_valid    (if_id_valid),
        .if_id_instr    (if_id_instr),
        .if_id_pc       (if_id_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h00A0_0093 ^ {a[23:0], 8'h00};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic mem_resp(input logic v, input logic [31:0] a);
        bus.imem_rvalid = v;
        bus.imem_rdata  = v ? mem_word(a) : 32'hDEAD_BEEF;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst = 1'b1;
        stall_i = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0000_0000;
        mem_resp(1'b0, 32'h0);
        step();
        step();
        chk("rst_req",   {31'd0, bus.imem_req}, 32'd0);
        chk("rst_valid", {31'd0, if_id_valid}, 32'd0);
        chk("rst_instr", if_id_instr, NOP);
        chk("rst_pc",    if_id_pc, 32'h0);

        rst = 1'b0;
        step();
        chk("first_req",  {31'd0, bus.imem_req}, 32'd1);
        chk("first_addr", bus.imem_addr, 32'h0);
        mem_resp(1'b1, 32'h0);
        step();
        chk("w0_valid", {31'd0, if_id_valid}, 32'd1);
        chk("w0_instr", if_id_instr, 32'h00A0_0093);
        chk("w0_pc",    if_id_pc, 32'h0);
        chk("w0_next_addr", bus.imem_addr, 32'h4);
        mem_resp(1'b0, 32'h0);
        step();
        mem_resp(1'b1, 32'h4);
        step();
        chk("w4_instr", if_id_instr, mem_word(32'h4));
        chk("w4_pc",    if_id_pc, 32'h4);
        chk("w4_next_addr", bus.imem_addr, 32'h8);

        // Stall three cycles while the word at 8 returns.
        stall_i = 1'b1;
        mem_resp(1'b0, 32'h0);
        step();
        mem_resp(1'b1, 32'h8);
        step();
        mem_resp(1'b0, 32'h0);
        chk("skid_req_low",   {31'd0, bus.imem_req}, 32'd0);
        chk("stall_hold_instr", if_id_instr, mem_word(32'h4));
        chk("stall_hold_pc",    if_id_pc, 32'h4);
        step();
        chk("wait_req_low",   {31'd0, bus.imem_req}, 32'd0);
        chk("wait_hold_valid", {31'd0, if_id_valid}, 32'd1);
        chk("wait_hold_instr", if_id_instr, mem_word(32'h4));
        stall_i = 1'b0;
        step();
        chk("skid_out_instr", if_id_instr, mem_word(32'h8));
        chk("skid_out_pc",    if_id_pc, 32'h8);
        chk("after_skid_req",  {31'd0, bus.imem_req}, 32'd1);
        chk("after_skid_addr", bus.imem_addr, 32'hC);

        // Redirect overriding stall while the request to 12 is outstanding.
        stall_i = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0102;
        step();
        redirect_valid = 1'b0;
        stall_i = 1'b0;
        chk("redir_valid", {31'd0, if_id_valid}, 32'd0);
        chk("redir_instr", if_id_instr, NOP);
        chk("drop_addr_old", bus.imem_addr, 32'hC);
        chk("drop_req", {31'd0, bus.imem_req}, 32'd1);
        mem_resp(1'b1, 32'hC);
        step();
        chk("redir_target_addr", bus.imem_addr, 32'h100);
        chk("drop_discard_valid", {31'd0, if_id_valid}, 32'd0);
        mem_resp(1'b1, 32'h100);
        step();
        chk("w100_instr", if_id_instr, mem_word(32'h100));
        chk("w100_pc",    if_id_pc, 32'h100);
        chk("w100_next_addr", bus.imem_addr, 32'h104);

        // Redirect coincident with rvalid: data dropped.
        mem_resp(1'b1, 32'h104);
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0010;
        step();
        redirect_valid = 1'b0;
        mem_resp(1'b0, 32'h0);
        chk("coinc_valid", {31'd0, if_id_valid}, 32'd0);
        chk("coinc_instr", if_id_instr, NOP);
        chk("coinc_addr",  bus.imem_addr, 32'h10);

        // Redirect to 0x40 during a 3-cycle request to 16.
        step();
        chk("slow_addr", bus.imem_addr, 32'h10);
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0040;
        step();
        redirect_valid = 1'b0;
        chk("slow_drop_addr", bus.imem_addr, 32'h10);
        chk("slow_drop_req",  {31'd0, bus.imem_req}, 32'd1);
        step();
        mem_resp(1'b1, 32'h10);
        step();
        mem_resp(1'b0, 32'h0);
        chk("slow_new_addr",  bus.imem_addr, 32'h40);
        chk("slow_no_leak",   {31'd0, if_id_valid}, 32'd0);
        chk("slow_no_leak_instr", if_id_instr, NOP);

        // Wrap-around: redirect low bits forced to zero, then fetch at the top word.
        mem_resp(1'b1, 32'h40);
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFF;
        step();
        redirect_valid = 1'b0;
        chk("top_addr", bus.imem_addr, 32'hFFFF_FFFC);
        mem_resp(1'b1, 32'hFFFF_FFFC);
        step();
        mem_resp(1'b0, 32'h0);
        chk("top_instr", if_id_instr, mem_word(32'hFFFF_FFFC));
        chk("top_pc",    if_id_pc, 32'hFFFF_FFFC);
        chk("wrap_addr", bus.imem_addr, 32'h0);
        chk("wrap_req",  {31'd0, bus.imem_req}, 32'd1);

        // Asynchronous reset between clock edges.
        #2;
        rst = 1'b1;
        #1;
        chk("async_req",   {31'd0, bus.imem_req}, 32'd0);
        chk("async_valid", {31'd0, if_id_valid}, 32'd0);
        chk("async_instr", if_id_instr, NOP);
        chk("async_pc",    if_id_pc, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        mem_resp(1'b1, 32'h8);
        step();
        mem_resp(1'b0, 32'h0);
        chk("stray_ignored", {31'd0, if_id_valid}, 32'd0);
        chk("restart_req",   {31'd0, bus.imem_req}, 32'd1);
        chk("restart_addr",  bus.imem_addr, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
